// File: rtl/stream_mux_rr_if.sv
// Bundle of N_CH producer streams plus one consumer stream around stream_mux_rr.
// slave is the mux side of the bus, master is the side that drives the producers and consumer.
interface stream_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CW-1:0]         out_ch;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/stream_mux_rr.sv
// Round-robin N-to-1 valid/ready stream mux with a registered output stage.
// One-cycle latency, one beat per clock; optionally holds the grant for a whole packet.
module stream_mux_rr #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int PKT_LOCK = 0
) (
  input logic            clk,
  input logic            rst,
  stream_mux_rr_if.slave bus
);
  localparam int CW = $clog2(N_CH);

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    lock_ch;
  logic             locked;
  logic [CW-1:0]    grant;
  logic             grant_vld;
  logic [CW:0]      probe;
  logic             free;
  logic             accept;
  logic [N_CH-1:0]  ready;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_ch_q;
  logic             out_last_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_split
    assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign free = !out_valid_q || bus.out_ready;

  // Search starts at ptr and wraps modulo N_CH; one extra bit keeps the sum from overflowing.
  always_comb begin
    grant     = ptr;
    grant_vld = 1'b0;
    probe     = '0;
    if (PKT_LOCK != 0 && locked) begin
      grant     = lock_ch;
      grant_vld = 1'b1;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        probe = {1'b0, ptr} + (CW+1)'(k);
        if (probe >= (CW+1)'(N_CH)) probe = probe - (CW+1)'(N_CH);
        if (!grant_vld && bus.in_valid[probe[CW-1:0]]) begin
          grant     = probe[CW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst && grant_vld) ready[grant] = free;
  end

  assign accept = !rst && grant_vld && bus.in_valid[grant] && free;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      ptr         <= '0;
      locked      <= 1'b0;
      lock_ch     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ch_data[grant];
      out_ch_q    <= grant;
      out_last_q  <= bus.in_last[grant];
      ptr         <= (grant == CW'(N_CH-1)) ? '0 : grant + CW'(1);
      if (PKT_LOCK != 0) begin
        locked  <= !bus.in_last[grant];
        lock_ch <= grant;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: dut_a runs per-beat arbitration, dut_b runs with packet lock.
// Expected beats are queued when stimulus is set up and compared as the DUT outputs them.
module tb_stream_mux_rr;
  typedef struct packed {
    logic [1:0] gap;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(4), .WIDTH(8)) bus_a ();
  stream_mux_rr_if #(.N_CH(4), .WIDTH(8)) bus_b ();

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .PKT_LOCK(0)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  stream_mux_rr #(.N_CH(4), .WIDTH(8), .PKT_LOCK(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_a [$];
  logic [10:0] exp_b [$];
  beat_t pq [4][$];
  int    gap_cnt [4];
  bit    started [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic last, input logic [1:0] ch, input logic [7:0] d);
    return {last, ch, d};
  endfunction

  function automatic beat_t mkb(input logic [1:0] gap, input logic last, input logic [7:0] d);
    beat_t b;
    b.gap  = gap;
    b.last = last;
    b.data = d;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboards: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_a === 1'b0 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
      check("a_pending", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0)
        check("a_beat", 32'({bus_a.out_last, bus_a.out_ch, bus_a.out_data}), 32'(exp_a.pop_front()));
    end
    if (rst_b === 1'b0 && bus_b.out_valid === 1'b1 && bus_b.out_ready === 1'b1) begin
      check("b_pending", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0)
        check("b_beat", 32'({bus_b.out_last, bus_b.out_ch, bus_b.out_data}), 32'(exp_b.pop_front()));
    end
  end

  // Producers for dut_b: each channel plays its queue; gap holds valid low before a beat.
  initial begin : producer_b
    logic [3:0]  fire;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    bus_b.in_valid = '0;
    bus_b.in_last  = '0;
    bus_b.in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      gap_cnt[i] = 0;
      started[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      fire = bus_b.in_valid & bus_b.in_ready;
      @(posedge clk);
      #1;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && pq[i].size() != 0) begin
          void'(pq[i].pop_front());
          started[i] = 1'b0;
        end
        if (pq[i].size() != 0 && !started[i]) begin
          gap_cnt[i] = int'(pq[i][0].gap);
          started[i] = 1'b1;
        end else if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
        end
        if (pq[i].size() != 0) begin
          v[i]         = (gap_cnt[i] == 0);
          l[i]         = pq[i][0].last;
          d[i*8 +: 8]  = pq[i][0].data;
        end
      end
      bus_b.in_valid = v;
      bus_b.in_last  = l;
      bus_b.in_data  = d;
    end
  end

  initial begin : main
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in_valid  = 4'b1111;
    bus_a.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_a.in_last   = '0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    tick();
    tick();
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_data", 32'(bus_a.out_data), 32'h0);
    check("rst_out_ch", 32'(bus_a.out_ch), 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'h0);
    check("rst_b_in_ready", 32'(bus_b.in_ready), 32'h0);

    // Round-robin with all channels valid: 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < 8; i++) exp_a.push_back(mk(1'b0, 2'(i % 4), 8'hA0 + 8'(i % 4)));
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) check("rr_first_ch", 32'(bus_a.out_ch), 32'd0);
      check("rr_throughput", 32'(bus_a.out_valid), 32'd1);
    end
    bus_a.in_valid = 4'b0000;
    tick();
    check("rr_idle", 32'(bus_a.out_valid), 32'd0);

    // Sparse requests: ch1 moves ptr to 2, then {3,1} wraps, then ch2 alone.
    exp_a.push_back(mk(1'b0, 2'd1, 8'hA1));
    bus_a.in_valid = 4'b0010;
    tick();
    exp_a.push_back(mk(1'b0, 2'd3, 8'hA3));
    exp_a.push_back(mk(1'b0, 2'd1, 8'hA1));
    bus_a.in_valid = 4'b1010;
    #1;
    check("sparse_grant_ch3", 32'(bus_a.in_ready), 32'b1000);
    tick();
    tick();
    for (int i = 0; i < 3; i++) exp_a.push_back(mk(1'b0, 2'd2, 8'hA2));
    bus_a.in_valid = 4'b0100;
    tick();
    tick();
    tick();
    bus_a.in_valid = 4'b0000;
    tick();
    tick();

    // Backpressure: ch3 loads, consumer stalls 3 cycles, then drain and reload together.
    exp_a.push_back(mk(1'b0, 2'd3, 8'hA3));
    exp_a.push_back(mk(1'b0, 2'd0, 8'hA0));
    bus_a.in_valid  = 4'b1111;
    bus_a.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(bus_a.in_ready), 32'h0);
      check("bp_out_data", 32'(bus_a.out_data), 32'hA3);
      check("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
      tick();
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus_a.in_ready), 32'b0001);
    tick();
    check("bp_no_bubble", 32'({bus_a.out_valid, bus_a.out_ch}), 32'({1'b1, 2'd0}));
    bus_a.in_valid = 4'b0000;
    tick();
    tick();

    // Packet lock: ch1 packet of three beats stays contiguous while ch0/ch2 keep requesting.
    pq[0].push_back(mkb(2'd0, 1'b1, 8'h01));
    pq[0].push_back(mkb(2'd0, 1'b1, 8'h02));
    pq[1].push_back(mkb(2'd0, 1'b0, 8'h11));
    pq[1].push_back(mkb(2'd0, 1'b0, 8'h12));
    pq[1].push_back(mkb(2'd0, 1'b1, 8'h13));
    pq[2].push_back(mkb(2'd0, 1'b1, 8'h21));
    pq[2].push_back(mkb(2'd0, 1'b1, 8'h22));
    exp_b.push_back(mk(1'b1, 2'd0, 8'h01));
    exp_b.push_back(mk(1'b0, 2'd1, 8'h11));
    exp_b.push_back(mk(1'b0, 2'd1, 8'h12));
    exp_b.push_back(mk(1'b1, 2'd1, 8'h13));
    exp_b.push_back(mk(1'b1, 2'd2, 8'h21));
    exp_b.push_back(mk(1'b1, 2'd0, 8'h02));
    exp_b.push_back(mk(1'b1, 2'd2, 8'h22));
    for (int i = 0; i < 12; i++) tick();
    check("lock_pkt_done", 32'(exp_b.size()), 32'd0);

    // Locked ch1 drops valid for 2 cycles: ch0/ch2 are valid but must not be granted.
    pq[1].push_back(mkb(2'd0, 1'b0, 8'h31));
    pq[1].push_back(mkb(2'd2, 1'b1, 8'h32));
    pq[0].push_back(mkb(2'd1, 1'b1, 8'h03));
    pq[2].push_back(mkb(2'd1, 1'b1, 8'h23));
    exp_b.push_back(mk(1'b0, 2'd1, 8'h31));
    exp_b.push_back(mk(1'b1, 2'd1, 8'h32));
    exp_b.push_back(mk(1'b1, 2'd2, 8'h23));
    exp_b.push_back(mk(1'b1, 2'd0, 8'h03));
    @(posedge clk);
    @(posedge clk);
    #3;
    check("lock_hold_ready1", 32'(bus_b.in_ready), 32'b0010);
    @(posedge clk);
    #3;
    check("lock_hold_ready2", 32'(bus_b.in_ready), 32'b0010);
    check("lock_hold_idle", 32'(bus_b.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("lock_gap_done", 32'(exp_b.size()), 32'd0);

    // Reset mid-packet: ch2 locks with its beat held, reset drops both.
    bus_b.out_ready = 1'b0;
    pq[2].push_back(mkb(2'd0, 1'b0, 8'h51));
    pq[2].push_back(mkb(2'd0, 1'b1, 8'h52));
    pq[1].push_back(mkb(2'd2, 1'b1, 8'h41));
    pq[3].push_back(mkb(2'd0, 1'b1, 8'h61));
    @(posedge clk);
    tick();
    check("mid_held", 32'({bus_b.out_valid, bus_b.out_ch, bus_b.out_data}), 32'({1'b1, 2'd2, 8'h51}));
    rst_b = 1'b1;
    pq[2].delete();
    started[2] = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus_b.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus_b.in_ready), 32'h0);
    exp_b.push_back(mk(1'b1, 2'd1, 8'h41));
    exp_b.push_back(mk(1'b1, 2'd3, 8'h61));
    rst_b = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    check("a_drained", 32'(exp_a.size()), 32'd0);
    check("b_drained", 32'(exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
